// File: rtl/keypad_display_mux.sv
// keypad_display_mux: two-entry key history feeding a time-multiplexed dual
// seven-segment display. The newest key is shown on the right digit and the
// previous key on the left.
// Optional build macro: DISPLAY_DEADTIME_EN blanks both anodes for the first
// DEADTIME_CYCLES counts of every slot to suppress ghosting.
module keypad_display_mux #(
  parameter int unsigned REFRESH_DIV     = 24000,
  parameter int unsigned DEADTIME_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_key,
  input  logic [3:0] digit,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] new_digit,
  output logic [3:0] old_digit
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

`ifdef DISPLAY_DEADTIME_EN
  localparam int unsigned DEAD_ON = 1;
`else
  localparam int unsigned DEAD_ON = 0;
`endif
  localparam logic [CNT_W:0] DEAD_LIM = (CNT_W + 1)'(DEADTIME_CYCLES * DEAD_ON);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

  typedef enum logic {
    SLOT_RIGHT = 1'b0,
    SLOT_LEFT  = 1'b1
  } slot_e;

  logic             vk_q, vk_d;
  logic [3:0]       new_digit_q, new_digit_d;
  logic [3:0]       old_digit_q, old_digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            sel_q, sel_d;

  // Output pipeline: stage 1 latches slot, chosen code and blank flag;
  // stage 2 holds the decoded pin drive.
  logic             disp_on_q, disp_on_d;
  slot_e            disp_sel_q, disp_sel_d;
  logic [3:0]       disp_code_q, disp_code_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             key_edge;
  logic             blank;
  logic [CNT_W:0]   cnt_plus1;
  logic [6:0]       seg_dec;

  // Key capture: rising-edge qualified shift of the two-entry history
  always_comb begin
    vk_d        = valid_key;
    key_edge    = valid_key & ~vk_q;
    new_digit_d = new_digit_q;
    old_digit_d = old_digit_q;
    if (key_edge) begin
      old_digit_d = new_digit_q;
      new_digit_d = digit;
    end
  end

  // Refresh counter and slot select next-state
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = (sel_q == SLOT_RIGHT) ? SLOT_LEFT : SLOT_RIGHT;
    end
  end

  // Stage 1: pick the digit for the current slot and the blanking window
  always_comb begin
    cnt_plus1   = {1'b0, cnt_q} + CNT_ONE;
    blank       = (cnt_plus1 <= DEAD_LIM);
    disp_on_d   = ~blank;
    disp_sel_d  = sel_q;
    disp_code_d = (sel_q == SLOT_RIGHT) ? new_digit_q : old_digit_q;
  end

  // Seven-segment decoder, active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg_dec = 7'h7F;
    case (disp_code_q)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Stage 2: pin drive; only one anode is ever enabled
  always_comb begin
    an_d  = 2'b11;
    seg_d = 7'h7F;
    if (disp_on_q) begin
      an_d  = (disp_sel_q == SLOT_RIGHT) ? 2'b10 : 2'b01;
      seg_d = seg_dec;
    end
  end

  // State registers; stage 1 resets to blank so the first edge still shows off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vk_q        <= 1'b0;
      new_digit_q <= '0;
      old_digit_q <= '0;
      cnt_q       <= '0;
      sel_q       <= SLOT_RIGHT;
      disp_on_q   <= 1'b0;
      disp_sel_q  <= SLOT_RIGHT;
      disp_code_q <= '0;
      an_q        <= '1;
      seg_q       <= '1;
    end else begin
      vk_q        <= vk_d;
      new_digit_q <= new_digit_d;
      old_digit_q <= old_digit_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      disp_on_q   <= disp_on_d;
      disp_sel_q  <= disp_sel_d;
      disp_code_q <= disp_code_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign new_digit = new_digit_q;
  assign old_digit = old_digit_q;

endmodule

// File: tb/tb_keypad_display_mux.sv
// Self-checking bench for keypad_display_mux with REFRESH_DIV=8,
// DEADTIME_CYCLES=2. A cycle model pushes expected {an,seg} into a scoreboard
// queue; a monitor pops and compares two edges later.
module tb_keypad_display_mux;

  localparam int unsigned RD = 8;
  localparam int unsigned DT = 2;
  localparam logic [8:0]  OFF = {2'b11, 7'h7F};

  logic       clk;
  logic       reset;
  logic       valid_key;
  logic [3:0] digit;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] new_digit;
  logic [3:0] old_digit;

  int checks   = 0;
  int failures = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [8:0]  sb [$];
  int unsigned m_cnt;
  logic        m_sel;
  logic [3:0]  m_new, m_old;
  logic        m_vk;

  keypad_display_mux #(.REFRESH_DIV(RD), .DEADTIME_CYCLES(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_key (valid_key),
    .digit     (digit),
    .seg       (seg),
    .an        (an),
    .new_digit (new_digit),
    .old_digit (old_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected output two edges after the state it is built from
  always @(posedge clk or negedge reset) begin
    logic [8:0] e;
    logic       blank_m;
    if (!reset) begin
      sb.delete();
      sb.push_back(OFF);
      m_cnt = 0; m_sel = 1'b0; m_new = 4'h0; m_old = 4'h0; m_vk = 1'b0;
    end else begin
`ifdef DISPLAY_DEADTIME_EN
      blank_m = (m_cnt < DT);
`else
      blank_m = 1'b0;
`endif
      if (blank_m)     e = OFF;
      else if (!m_sel) e = {2'b10, dec_tab[m_new]};
      else             e = {2'b01, dec_tab[m_old]};
      sb.push_back(e);
      if (valid_key && !m_vk) begin
        m_old = m_new;
        m_new = digit;
      end
      m_vk = valid_key;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_sel = ~m_sel;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset && sb.size() >= 2) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t an=%b seg=%h expected an=%b seg=%h",
                 $time, an, seg, e[8:7], e[6:0]);
      end
      checks++;
      if (an === 2'b00) begin
        failures++;
        $display("FAIL both_anodes t=%0t an=%b required not 00", $time, an);
      end
    end
  end

  task automatic pulse(input logic [3:0] d);
    @(negedge clk);
    valid_key = 1'b1;
    digit     = d;
    @(negedge clk);
    valid_key = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulse(4'h7);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg} !== OFF) begin
      failures++;
      $display("FAIL reset_out an=%b seg=%h expected an=11 seg=7f", an, seg);
    end
    checks++;
    if ({new_digit, old_digit} !== 8'h00) begin
      failures++;
      $display("FAIL reset_digits new=%h old=%h expected 0 0", new_digit, old_digit);
    end
    @(negedge clk);
    checks++;
    if ({an, seg, new_digit, old_digit} !== {OFF, 8'h00}) begin
      failures++;
      $display("FAIL reset_hold an=%b seg=%h new=%h old=%h expected 11 7f 0 0",
               an, seg, new_digit, old_digit);
    end
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 1) begin
        checks++;
        if ({an, seg} !== OFF) begin
          failures++;
          $display("FAIL reset_edge1 an=%b seg=%h expected 11 7f", an, seg);
        end
      end
`ifdef DISPLAY_DEADTIME_EN
      if (e == 4) begin
`else
      if (e == 2) begin
`endif
        checks++;
        if ({an, seg} !== {2'b10, 7'h40}) begin
          failures++;
          $display("FAIL reset_first_right edge=%0d an=%b seg=%h expected 10 40", e, an, seg);
        end
      end
      if (e == 9) begin
        checks++;
        if (an !== 2'b10) begin
          failures++;
          $display("FAIL reset_edge9 an=%b expected 10", an);
        end
      end
`ifdef DISPLAY_DEADTIME_EN
      if (e == 12) begin
`else
      if (e == 10) begin
`endif
        checks++;
        if ({an, seg} !== {2'b01, 7'h40}) begin
          failures++;
          $display("FAIL reset_first_left edge=%0d an=%b seg=%h expected 01 40", e, an, seg);
        end
      end
    end
  endtask

  task automatic test_pulse;
    pulse(4'h5);
    pulse(4'hA);
    @(negedge clk);
    checks++;
    if ({new_digit, old_digit} !== 8'hA5) begin
      failures++;
      $display("FAIL pulse_digits new=%h old=%h expected a 5", new_digit, old_digit);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40 && an !== 2'b01; i++) @(negedge clk);
    checks++;
    if ({an, seg} !== {2'b01, 7'h12}) begin
      failures++;
      $display("FAIL pulse_left an=%b seg=%h expected 01 12", an, seg);
    end
    for (int i = 0; i < 40 && an !== 2'b10; i++) @(negedge clk);
    checks++;
    if ({an, seg} !== {2'b10, 7'h08}) begin
      failures++;
      $display("FAIL pulse_right an=%b seg=%h expected 10 08", an, seg);
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    valid_key = 1'b1;
    digit     = 4'h3;
    repeat (5) @(negedge clk);
    valid_key = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({new_digit, old_digit} !== 8'h3A) begin
      failures++;
      $display("FAIL hold_single_shift new=%h old=%h expected 3 a", new_digit, old_digit);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    for (int i = 0; i < 40 && !(m_cnt == RD - 1 && m_sel == 1'b0); i++) @(negedge clk);
    valid_key = 1'b1;
    digit     = 4'hC;
    @(negedge clk);
    valid_key = 1'b0;
    checks++;
    if ({new_digit, old_digit} !== 8'hC3) begin
      failures++;
      $display("FAIL wrap_digits new=%h old=%h expected c 3", new_digit, old_digit);
    end
    @(negedge clk);
    checks++;
    if (an !== 2'b10) begin
      failures++;
      $display("FAIL wrap_prev_slot an=%b expected 10", an);
    end
`ifdef DISPLAY_DEADTIME_EN
    repeat (3) @(negedge clk);
`else
    @(negedge clk);
`endif
    checks++;
    if ({an, seg} !== {2'b01, 7'h30}) begin
      failures++;
      $display("FAIL wrap_new_slot an=%b seg=%h expected 01 30", an, seg);
    end
  endtask

  task automatic test_sweep;
    for (int d = 0; d < 16; d++) begin
      pulse(4'(d));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 40 && an !== 2'b10; i++) @(negedge clk);
      checks++;
      if ({an, seg, new_digit} !== {2'b10, dec_tab[d], 4'(d)}) begin
        failures++;
        $display("FAIL sweep_%0h an=%b seg=%h new=%h expected 10 %h %h",
                 d, an, seg, new_digit, dec_tab[d], d);
      end
    end
  endtask

  task automatic test_deadtime;
    int blanks;
    int exp_blanks;
    blanks = 0;
`ifdef DISPLAY_DEADTIME_EN
    exp_blanks = 12;
`else
    exp_blanks = 0;
`endif
    repeat (48) begin
      @(negedge clk);
      if (an === 2'b11) blanks++;
    end
    checks++;
    if (blanks !== exp_blanks) begin
      failures++;
      $display("FAIL deadtime_blanks count=%0d expected %0d", blanks, exp_blanks);
    end
  endtask

  initial begin
    reset     = 1'b0;
    valid_key = 1'b0;
    digit     = 4'h0;
    test_reset();
    test_pulse();
    test_hold();
    test_wrap();
    test_sweep();
    test_deadtime();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
